// File: rtl/imem_loader_if.sv
// Stream-in and memory-write signal bundle for the instruction memory loader.
// Stream handshake: a byte moves on a rising edge only when in_valid && in_ready are both 1;
// the source holds in_byte stable while in_valid=1 and in_ready=0, and in_ready never depends on in_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;
  logic [1:0]        dbg_state;

  modport master (
    output start, word_count, abort, in_byte, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold, dbg_state
  );

  modport slave (
    input  start, word_count, abort, in_byte, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold, dbg_state
  );
endinterface

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream, packing bytes big-endian into 32-bit words
// written to consecutive word indices from 0; holds the CPU until the image is complete.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              err_q, err_d;
  logic              take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      wc_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      wc_q      <= wc_d;
      err_q     <= err_d;
    end
  end

  // in_ready is decoded from state alone, so a byte is taken whenever RECV sees in_valid.
  assign take = bus.in_valid && (state_q == S_RECV);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    wc_d      = wc_q;
    err_d     = err_q;

    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            wc_d = bus.word_count;
            if (bus.word_count == '0) begin
              state_d = S_DONE;
              err_d   = 1'b0;
            end else if (bus.word_count > MAX_WORDS) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              state_d   = S_RECV;
              wr_addr_d = '0;
              cnt_d     = '0;
              err_d     = 1'b0;
            end
          end
        end
        S_RECV: begin
          if (take) begin
            word_d = {word_q[23:0], bus.in_byte};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if ({1'b0, wr_addr_q} == wc_q - ONE_WORD) begin
            state_d = S_DONE;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = S_RECV;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_RECV);
  assign bus.wr_en     = (state_q == S_WRITE);
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = word_q;
  assign bus.busy      = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.cpu_hold  = !((state_q == S_DONE) && !err_q);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a word-list model of the byte stream.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [ADDR_W+31:0] wr_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();
  imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int last_wr_addr = -1;
  wr_t exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = int'(bus.wr_addr);
      if (exp_q.size() == 0) chk("unexpected_write", 64'(exp_q.size()), 64'd1);
      else chk("write", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    bus.in_byte = '0; bus.word_count = '0;
  endtask

  task automatic pulse_start(input int wc);
    bus.word_count = (ADDR_W+1)'(wc);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t b;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
    return b;
  endfunction

  // Model: word i of the image is bytes 4i..4i+3 most significant first, written at index i.
  task automatic expect_words(input byte_q_t b, input int nwords);
    for (int i = 0; i < nwords; i++)
      exp_q.push_back({ADDR_W'(i), b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
  endtask

  task automatic send_bytes(input byte_q_t b, input int first, input int n,
                            input int min_gap, input int max_gap, input bit chk_ready);
    logic acc;
    int guard;
    for (int i = first; i < first + n; i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(min_gap, max_gap)) begin
        if (chk_ready && bus.busy && !bus.wr_en) chk("ready_in_recv", bus.in_ready, 1'b1);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_byte  = b[i];
      guard = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 20);
      if (!acc) chk("accept_timeout", 64'(guard), 64'd0);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.done !== 1'b1 && guard < 50);
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_done_lat"}, 64'(cyc - last_wr_cyc), 64'd1);
    chk({tag, "_cpu_hold"}, bus.cpu_hold, 1'b0);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic run_load(input string tag, input int wc, input byte_q_t b,
                          input int min_gap, input int max_gap, input bit chk_ready);
    int w0 = wr_cnt;
    expect_words(b, wc);
    pulse_start(wc);
    send_bytes(b, 0, 4 * wc, min_gap, max_gap, chk_ready);
    wait_done(tag);
    chk({tag, "_nwrites"}, 64'(wr_cnt - w0), 64'(wc));
  endtask

  initial begin
    byte_q_t b;
    int w0;
    idle_inputs();

    // T1 reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_cpu_hold", bus.cpu_hold, 1'b1);
    chk("rst_wr_addr", bus.wr_addr, '0);
    chk("rst_wr_data", bus.wr_data, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    chk("idle_in_ready", bus.in_ready, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);

    // T2 two-word load
    b = '{8'h3C, 8'h08, 8'h12, 8'h34, 8'h20, 8'h08, 8'h00, 8'h01};
    run_load("t2", 2, b, 0, 0, 1'b1);

    // T3 same load with in_valid toggling
    run_load("t3", 2, b, 1, 1, 1'b1);

    // Randomized loads with random stalls
    for (int k = 0; k < 4; k++) begin
      int wc = $urandom_range(1, 6);
      run_load("rnd", wc, rand_bytes(4 * wc), 0, 2, 1'b1);
    end

    // T4 word_count = 0
    pulse_abort();
    w0 = wr_cnt;
    pulse_start(0);
    @(negedge clk);
    chk("wc0_done", bus.done, 1'b1);
    chk("wc0_err", bus.err, 1'b0);
    chk("wc0_cpu_hold", bus.cpu_hold, 1'b0);
    chk("wc0_busy", bus.busy, 1'b0);
    #1;

    // T4 word_count = 1025 (over capacity)
    pulse_abort();
    pulse_start(1025);
    @(negedge clk);
    chk("wc1025_done", bus.done, 1'b1);
    chk("wc1025_err", bus.err, 1'b1);
    chk("wc1025_cpu_hold", bus.cpu_hold, 1'b1);
    repeat (3) @(negedge clk);
    chk("wc_bad_nwrites", 64'(wr_cnt - w0), 64'd0);
    #1;

    // T4 word_count = 1024 (full memory)
    run_load("wc1024", 1024, rand_bytes(4096), 0, 0, 1'b0);
    chk("wc1024_last_addr", 64'(last_wr_addr), 64'd1023);

    // abort and start together: abort wins
    bus.word_count = (ADDR_W+1)'(2);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    chk("abort_start_busy", bus.busy, 1'b0);
    chk("abort_start_done", bus.done, 1'b0);

    // T5 abort after 6 bytes of a 3-word load
    w0 = wr_cnt;
    b = rand_bytes(12);
    expect_words(b, 1);
    pulse_start(3);
    send_bytes(b, 0, 6, 0, 1, 1'b0);
    pulse_abort();
    @(negedge clk);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_done", bus.done, 1'b0);
    chk("t5_in_ready", bus.in_ready, 1'b0);
    chk("t5_cpu_hold", bus.cpu_hold, 1'b1);
    chk("t5_nwrites", 64'(wr_cnt - w0), 64'd1);
    chk("t5_left", 64'(exp_q.size()), 64'd0);
    #1;
    run_load("t5_reload", 1, rand_bytes(4), 0, 1, 1'b1);

    // T6 async reset between edges mid-RECV
    b = rand_bytes(8);
    pulse_start(2);
    send_bytes(b, 0, 3, 0, 0, 1'b0);
    @(negedge clk);
    chk("t6_pre_busy", bus.busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_in_ready", bus.in_ready, 1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_wr_en", bus.wr_en, 1'b0);
    chk("t6_wr_addr", bus.wr_addr, '0);
    chk("t6_wr_data", bus.wr_data, '0);
    chk("t6_done", bus.done, 1'b0);
    chk("t6_err", bus.err, 1'b0);
    chk("t6_cpu_hold", bus.cpu_hold, 1'b1);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    run_load("t6_after", 1, rand_bytes(4), 0, 0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
